// File: rtl/hdsiso_pattern_gen.sv
// Test-pattern source (Fibonacci LFSR / external pad) for the HD SISO chain, with an optional
// self-synchronising return-path checker built only when HDSISO_PATTERN_CHECK_EN is defined.
module hdsiso_pattern_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int               LOSS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lfsr_en,
  input  logic       din_sel,
  input  logic       d_ext,
  output logic       d_in,
  output logic       lfsr_bit,
  output logic       lfsr_period,
  input  logic       d_ret,
  input  logic       d_ret_vld,
  output logic       locked,
  output logic       err_flag,
  output logic [7:0] err_count
);

  // An all-zero seed would park the LFSR in lock-up, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_next;

  always_comb begin
    s_next = s;
    if (s == '0)
      s_next = SEED_EFF;
    else if (lfsr_en)
      s_next = {s[WIDTH-2:0], ^(s & TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s           <= SEED_EFF;
      d_in        <= 1'b0;
      lfsr_period <= 1'b0;
    end else begin
      s           <= s_next;
      d_in        <= din_sel ? s[WIDTH-1] : d_ext;
      lfsr_period <= lfsr_en && (s_next == SEED_EFF);
    end
  end

  assign lfsr_bit = s[WIDTH-1];

`ifdef HDSISO_PATTERN_CHECK_EN
  localparam int LW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(LOSS + 1);

  localparam logic [0:0] ST_SYNC  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] rx;
  logic [LW-1:0]    load_cnt;
  logic [CW-1:0]    miss_cnt;
  logic [7:0]       err_cnt;
  logic             err_q;
  logic             pred;
  logic             mismatch;

  // The returned stream obeys the same recurrence as the generator, so rx predicts its next bit.
  assign pred     = ^(rx & TAPS);
  assign mismatch = (d_ret != pred) || (rx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_SYNC;
      rx       <= '0;
      load_cnt <= '0;
      miss_cnt <= '0;
      err_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (d_ret_vld) begin
        rx <= {rx[WIDTH-2:0], d_ret};
        if (state == ST_SYNC) begin
          if (load_cnt == LW'(WIDTH - 1)) begin
            state    <= ST_TRACK;
            load_cnt <= '0;
          end else begin
            load_cnt <= load_cnt + LW'(1);
          end
        end else if (mismatch) begin
          err_q <= 1'b1;
          if (err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
          // The bit that breaks lock is already shifted into rx, so it counts as the first load.
          if (miss_cnt == CW'(LOSS - 1)) begin
            state    <= ST_SYNC;
            load_cnt <= LW'(1);
            miss_cnt <= '0;
          end else begin
            miss_cnt <= miss_cnt + CW'(1);
          end
        end else begin
          miss_cnt <= '0;
        end
      end
    end
  end

  assign locked    = (state == ST_TRACK);
  assign err_flag  = err_q;
  assign err_count = err_cnt;
`else
  logic _unused;
  assign _unused   = &{1'b0, d_ret, d_ret_vld};
  assign locked    = 1'b0;
  assign err_flag  = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_hdsiso_pattern_gen.sv
// Directed self-checking bench for hdsiso_pattern_gen; checker tests are compiled in when
// HDSISO_PATTERN_CHECK_EN is defined, otherwise the tied-off outputs are checked.
module tb_hdsiso_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       lfsr_en;
  logic       din_sel;
  logic       d_ext;
  logic       d_in;
  logic       lfsr_bit;
  logic       lfsr_period;
  logic       d_ret;
  logic       d_ret_vld;
  logic       locked;
  logic       err_flag;
  logic [7:0] err_count;

  int checks = 0;
  int passes = 0;

  // Loopback delay line; dly[4] is the next bit presented on d_ret, dly[3:1] the ones after it.
  logic [4:0] dly;
  logic       stuck_on;
  logic       stuck_val;

  hdsiso_pattern_gen dut (
    .clk        (clk),
    .rst        (rst),
    .lfsr_en    (lfsr_en),
    .din_sel    (din_sel),
    .d_ext      (d_ext),
    .d_in       (d_in),
    .lfsr_bit   (lfsr_bit),
    .lfsr_period(lfsr_period),
    .d_ret      (d_ret),
    .d_ret_vld  (d_ret_vld),
    .locked     (locked),
    .err_flag   (err_flag),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp)
      passes++;
    else
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: sample just after the edge, then refresh the loopback data for the next edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    dly   = {dly[3:0], d_in};
    d_ret = stuck_on ? stuck_val : dly[4];
  endtask

  task automatic waitWindow(input logic [3:0] pat, output logic found);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      applyStimulus();
      if (dly[4:1] == pat)
        found = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] lb_vec;
    logic [11:0] din_vec;
    logic [3:0]  resume_vec;
    logic [8:0]  ext_vec;
    logic [7:0]  post_vec;
    logic [9:0]  flag_vec;
    logic        found;
    int          npulse;
    int          p1;
    int          p2;
    int          bad;

    rst = 1'b1; lfsr_en = 1'b0; din_sel = 1'b1; d_ext = 1'b0;
    d_ret = 1'b0; d_ret_vld = 1'b0; dly = '0; stuck_on = 1'b0; stuck_val = 1'b0;
    lb_vec = '0; din_vec = '0; resume_vec = '0; ext_vec = '0; post_vec = '0; flag_vec = '0;
    npulse = 0; p1 = 0; p2 = 0; bad = 0; found = 1'b0;
    $display("[TB] hdsiso_pattern_gen bench start");

    repeat (2) applyStimulus();
    checkOutput("rst_d_in",      32'(d_in),        32'd0);
    checkOutput("rst_lfsr_bit",  32'(lfsr_bit),    32'd0);
    checkOutput("rst_period",    32'(lfsr_period), 32'd0);
    checkOutput("rst_locked",    32'(locked),      32'd0);
    checkOutput("rst_err_flag",  32'(err_flag),    32'd0);
    checkOutput("rst_err_count", 32'(err_count),   32'd0);
    rst = 1'b0;

    // States 01,02,04,08,11,23,47,8E,1C,38,71,E2,C4: MSB set at 8E, E2, C4.
    lfsr_en = 1'b1;
    for (int k = 1; k <= 517; k++) begin
      applyStimulus();
      if (k <= 12) begin
        lb_vec[k-1]  = lfsr_bit;
        din_vec[k-1] = d_in;
      end
      if (lfsr_period) begin
        npulse++;
        if (npulse == 1) p1 = k;
        else if (npulse == 2) p2 = k;
      end
    end
    checkOutput("lfsr_bit_seq",   32'(lb_vec),  32'h0C40);
    checkOutput("d_in_delay_seq", 32'(din_vec), 32'h0880);
    checkOutput("period_count",   32'(npulse),  32'd2);
    checkOutput("period_first",   32'(p1),      32'd255);
    checkOutput("period_second",  32'(p2),      32'd510);
    checkOutput("state_517_msb",  32'(lfsr_bit), 32'd1);

    // Frozen at 8E, then resume through 1C,38,71,E2.
    lfsr_en = 1'b0;
    bad = 0;
    repeat (10) begin
      applyStimulus();
      if (lfsr_bit !== 1'b1 || d_in !== 1'b1 || lfsr_period !== 1'b0) bad++;
    end
    checkOutput("freeze_hold", 32'(bad), 32'd0);
    lfsr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      resume_vec[i] = lfsr_bit;
    end
    checkOutput("resume_seq", 32'(resume_vec), 32'h8);
    lfsr_en = 1'b0;

    din_sel = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d_ext = (i % 2 == 1);
      applyStimulus();
      ext_vec[i] = d_in;
    end
    checkOutput("ext_follow", 32'(ext_vec), 32'h0AA);
    din_sel = 1'b1;
    applyStimulus();
    checkOutput("switch_back_lfsr", 32'(d_in), 32'd1);

    lfsr_en = 1'b1;
`ifdef HDSISO_PATTERN_CHECK_EN
    repeat (8) applyStimulus();
    d_ret_vld = 1'b1;
    repeat (7) applyStimulus();
    checkOutput("lock_after_7", 32'(locked), 32'd0);
    applyStimulus();
    checkOutput("lock_after_8", 32'(locked), 32'd1);

    bad = 0;
    repeat (2000) begin
      applyStimulus();
      if (!locked || err_flag) bad++;
    end
    checkOutput("loop_clean_cycles", 32'(bad),       32'd0);
    checkOutput("loop_err_count",    32'(err_count), 32'd0);

    // Flip a 0 into a 1 so the corrupted history can never read as all-zero.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      applyStimulus();
      if (dly[4] == 1'b0) found = 1'b1;
    end
    checkOutput("flip_window", 32'(found), 32'd1);
    d_ret = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      flag_vec[i] = err_flag;
    end
    checkOutput("flip_err_offsets", 32'(flag_vec),  32'h171);
    checkOutput("flip_err_count",   32'(err_count), 32'd5);
    checkOutput("flip_locked",      32'(locked),    32'd1);

    waitWindow(4'b0000, found);
    checkOutput("stuck1_window", 32'(found), 32'd1);
    stuck_on = 1'b1; stuck_val = 1'b1; d_ret = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("stuck1_locked_3", 32'(locked), 32'd1);
    applyStimulus();
    checkOutput("stuck1_locked_4", 32'(locked),    32'd0);
    checkOutput("stuck1_err_count", 32'(err_count), 32'd9);
    stuck_on = 1'b0;
`else
    d_ret_vld = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus();
      if (i == 50) d_ret = ~d_ret;
      if (locked || err_flag || err_count != 8'd0) bad++;
    end
    checkOutput("nochk_tied_off", 32'(bad),       32'd0);
    checkOutput("nochk_locked",   32'(locked),    32'd0);
    checkOutput("nochk_err",      32'(err_count), 32'd0);
`endif

    rst = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("midrst_d_in",      32'(d_in),        32'd0);
    checkOutput("midrst_lfsr_bit",  32'(lfsr_bit),    32'd0);
    checkOutput("midrst_period",    32'(lfsr_period), 32'd0);
    checkOutput("midrst_locked",    32'(locked),      32'd0);
    checkOutput("midrst_err_flag",  32'(err_flag),    32'd0);
    checkOutput("midrst_err_count", 32'(err_count),   32'd0);
    rst = 1'b0;
    d_ret_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      post_vec[i] = lfsr_bit;
    end
    checkOutput("midrst_restart_seq", 32'(post_vec), 32'h40);

`ifdef HDSISO_PATTERN_CHECK_EN
    d_ret_vld = 1'b1;
    repeat (8) applyStimulus();
    checkOutput("relock", 32'(locked), 32'd1);

    waitWindow(4'b1111, found);
    checkOutput("stuck0_window", 32'(found), 32'd1);
    checkOutput("stuck0_err_before", 32'(err_count), 32'd0);
    stuck_on = 1'b1; stuck_val = 1'b0; d_ret = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("stuck0_locked_3", 32'(locked), 32'd1);
    applyStimulus();
    checkOutput("stuck0_locked_4",  32'(locked),    32'd0);
    checkOutput("stuck0_err_count", 32'(err_count), 32'd4);
    stuck_on = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
